// File: rtl/ball_vga_if.sv
// Pin bundle between a keyboard/display host and the ball VGA engine.
// Host -> engine : kvalid (make-code strobe), kdata (scan code), swh (display mode)
// Engine -> host : hsync/vsync (active-low), R/G/B pixel colour, frame_start pulse,
//                  sel (index of the currently selected ball)
interface ball_vga_if;
    logic       kvalid;
    logic [7:0] kdata;
    logic [1:0] swh;
    logic       hsync;
    logic       vsync;
    logic       R;
    logic       G;
    logic       B;
    logic       frame_start;
    logic [1:0] sel;

    modport master (
        output kvalid, kdata, swh,
        input  hsync, vsync, R, G, B, frame_start, sel
    );

    modport slave (
        input  kvalid, kdata, swh,
        output hsync, vsync, R, G, B, frame_start, sel
    );
endinterface

// File: rtl/ball_vga_engine.sv
// VGA timing generator that draws NBALL filled (or outlined) circles which can be
// moved, resized and selected from keyboard make codes.
// Ports:
//   clk     - pixel clock, single clock domain
//   reset   - asynchronous active-low reset
//   io_bus  - ball_vga_if.slave: kvalid/kdata/swh in; hsync, vsync, R, G, B,
//             frame_start, sel out. All outputs are registered and lag the
//             column/row counters by two clocks.
module ball_vga_engine #(
    parameter int          H_ACTIVE   = 800,
    parameter int          H_FRONT    = 56,
    parameter int          H_SYNC     = 120,
    parameter int          H_BACK     = 64,
    parameter int          V_ACTIVE   = 600,
    parameter int          V_FRONT    = 37,
    parameter int          V_SYNC     = 6,
    parameter int          V_BACK     = 23,
    parameter int          NBALL      = 2,
    parameter int          STEP       = 1,
    parameter int          R_MIN      = 8,
    parameter int          R_MAX      = 60,
    parameter int          R_INIT     = 35,
    parameter logic [2:0]  BG_COLOR   = 3'b111,
    // Ball 0 occupies bits [2:0]: ball0=110, ball1=011, ball2=101, ball3=100
    parameter logic [11:0] BALL_COLOR = {3'b100, 3'b101, 3'b011, 3'b110}
) (
    input  logic       clk,
    input  logic       reset,
    ball_vga_if.slave  io_bus
);

    localparam logic [11:0] HT_M1    = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [11:0] VT_M1    = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [11:0] HA       = 12'(H_ACTIVE);
    localparam logic [11:0] VA       = 12'(V_ACTIVE);
    localparam logic [11:0] HA_M1    = 12'(H_ACTIVE - 1);
    localparam logic [11:0] VA_M1    = 12'(V_ACTIVE - 1);
    localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [11:0] ST       = 12'(STEP);
    localparam logic [11:0] RMIN     = 12'(R_MIN);
    localparam logic [11:0] RMAX     = 12'(R_MAX);
    localparam logic [1:0]  SEL_MAX  = 2'(NBALL - 1);

    typedef enum logic [2:0] {
        CmdNone, CmdUp, CmdDown, CmdLeft, CmdRight, CmdGrow, CmdShrink
    } cmd_e;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [11:0] r_col;
    logic [11:0] r_row;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_col == HT_M1) begin
            r_col <= '0;
            r_row <= (r_row == VT_M1) ? 12'd0 : r_row + 12'd1;
        end else begin
            r_col <= r_col + 12'd1;
        end
    end

    logic w_vis;
    logic w_hs;
    logic w_vs;
    logic w_fs;
    logic w_apply;

    assign w_vis   = (r_col < HA) && (r_row < VA);
    assign w_hs    = !((r_col >= HS_BEG) && (r_col < HS_END));
    assign w_vs    = !((r_row >= VS_BEG) && (r_row < VS_END));
    assign w_fs    = (r_col == 12'd0) && (r_row == 12'd0);
    // First blanking line: the only cycle in which ball geometry may change
    assign w_apply = (r_col == 12'd0) && (r_row == VA);

    // ------------------------------------------------------------------
    // Ball state
    // ------------------------------------------------------------------
    logic [11:0] r_cx  [NBALL];
    logic [11:0] r_cy  [NBALL];
    logic [11:0] r_rad [NBALL];
    logic [1:0]  r_sel;
    cmd_e        r_pend;

    cmd_e w_key_cmd;
    logic w_key_sel;

    always_comb begin
        w_key_cmd = CmdNone;
        if (io_bus.kvalid) begin
            case (io_bus.kdata)
                8'h1D:   w_key_cmd = CmdUp;
                8'h1B:   w_key_cmd = CmdDown;
                8'h1C:   w_key_cmd = CmdLeft;
                8'h23:   w_key_cmd = CmdRight;
                8'h79:   w_key_cmd = CmdGrow;
                8'h7B:   w_key_cmd = CmdShrink;
                default: w_key_cmd = CmdNone;
            endcase
        end
    end

    assign w_key_sel = io_bus.kvalid && (io_bus.kdata == 8'h0D);

    logic [11:0] w_cur_cx;
    logic [11:0] w_cur_cy;
    logic [11:0] w_cur_r;
    logic [11:0] w_xhi;
    logic [11:0] w_yhi;
    logic [11:0] w_nr;
    logic [11:0] w_new_cx;
    logic [11:0] w_new_cy;
    logic [11:0] w_new_r;

    // Next geometry of the selected ball under the pending command
    always_comb begin
        w_cur_cx = r_cx[0];
        w_cur_cy = r_cy[0];
        w_cur_r  = r_rad[0];
        for (int i = 0; i < NBALL; i++) begin
            if (2'(i) == r_sel) begin
                w_cur_cx = r_cx[i];
                w_cur_cy = r_cy[i];
                w_cur_r  = r_rad[i];
            end
        end
        w_xhi    = HA_M1 - w_cur_r;
        w_yhi    = VA_M1 - w_cur_r;
        w_nr     = w_cur_r + 12'd1;
        w_new_cx = w_cur_cx;
        w_new_cy = w_cur_cy;
        w_new_r  = w_cur_r;
        case (r_pend)
            CmdUp:    w_new_cy = (w_cur_cy >= w_cur_r + ST) ? w_cur_cy - ST : w_cur_r;
            CmdDown:  w_new_cy = (w_cur_cy + ST <= w_yhi) ? w_cur_cy + ST : w_yhi;
            CmdLeft:  w_new_cx = (w_cur_cx >= w_cur_r + ST) ? w_cur_cx - ST : w_cur_r;
            CmdRight: w_new_cx = (w_cur_cx + ST <= w_xhi) ? w_cur_cx + ST : w_xhi;
            CmdGrow: begin
                // A grow that would push the rim past any edge is dropped
                if ((w_nr <= RMAX) && (w_cur_cx >= w_nr) && (w_cur_cx + w_nr <= HA_M1)
                    && (w_cur_cy >= w_nr) && (w_cur_cy + w_nr <= VA_M1)) begin
                    w_new_r = w_nr;
                end
            end
            CmdShrink: begin
                if (w_cur_r > RMIN) begin
                    w_new_r = w_cur_r - 12'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel  <= 2'd0;
            r_pend <= CmdNone;
            for (int i = 0; i < NBALL; i++) begin
                r_cx[i]  <= 12'((i + 1) * H_ACTIVE / (NBALL + 1));
                r_cy[i]  <= 12'(V_ACTIVE / 2);
                r_rad[i] <= 12'(R_INIT);
            end
        end else begin
            if (w_key_sel) begin
                r_sel <= (r_sel == SEL_MAX) ? 2'd0 : r_sel + 2'd1;
            end
            if (w_apply) begin
                for (int i = 0; i < NBALL; i++) begin
                    if (2'(i) == r_sel) begin
                        r_cx[i]  <= w_new_cx;
                        r_cy[i]  <= w_new_cy;
                        r_rad[i] <= w_new_r;
                    end
                end
                // A key arriving in the apply cycle waits for the next frame
                r_pend <= w_key_cmd;
            end else if (w_key_cmd != CmdNone) begin
                r_pend <= w_key_cmd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline, stage 1: squared distances
    // ------------------------------------------------------------------
    logic [11:0] w_dx    [NBALL];
    logic [11:0] w_dy    [NBALL];
    logic [21:0] w_dx_ex [NBALL];
    logic [21:0] w_dy_ex [NBALL];
    logic [21:0] r_dx2   [NBALL];
    logic [21:0] r_dy2   [NBALL];
    logic        r_vis1;
    logic        r_hs1;
    logic        r_vs1;
    logic        r_fs1;

    always_comb begin
        for (int i = 0; i < NBALL; i++) begin
            w_dx[i]    = r_col - r_cx[i];
            w_dy[i]    = r_row - r_cy[i];
            // Sign-extend so the low bits of the product are the signed square
            w_dx_ex[i] = {{10{w_dx[i][11]}}, w_dx[i]};
            w_dy_ex[i] = {{10{w_dy[i][11]}}, w_dy[i]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NBALL; i++) begin
                r_dx2[i] <= '0;
                r_dy2[i] <= '0;
            end
            r_vis1 <= 1'b0;
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            r_fs1  <= 1'b0;
        end else begin
            for (int i = 0; i < NBALL; i++) begin
                r_dx2[i] <= w_dx_ex[i] * w_dx_ex[i];
                r_dy2[i] <= w_dy_ex[i] * w_dy_ex[i];
            end
            r_vis1 <= w_vis;
            r_hs1  <= w_hs;
            r_vs1  <= w_vs;
            r_fs1  <= w_fs;
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline, stage 2: hit test and colour
    // ------------------------------------------------------------------
    logic [22:0]      w_sum   [NBALL];
    logic [11:0]      w_rin   [NBALL];
    logic [21:0]      w_rsq   [NBALL];
    logic [21:0]      w_rinsq [NBALL];
    logic [NBALL-1:0] w_hit;
    logic [2:0]       w_color;
    logic [2:0]       r_rgb;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_fs;

    always_comb begin
        w_color = (io_bus.swh == 2'b11) ? 3'b000 : BG_COLOR;
        w_hit   = '0;
        for (int i = 0; i < NBALL; i++) begin
            w_sum[i]   = {1'b0, r_dx2[i]} + {1'b0, r_dy2[i]};
            w_rin[i]   = (r_rad[i] > 12'd2) ? r_rad[i] - 12'd2 : 12'd0;
            w_rsq[i]   = {10'd0, r_rad[i]} * {10'd0, r_rad[i]};
            w_rinsq[i] = {10'd0, w_rin[i]} * {10'd0, w_rin[i]};
            w_hit[i]   = (w_sum[i] < {1'b0, w_rsq[i]})
                         && ((io_bus.swh != 2'b10) || (w_sum[i] >= {1'b0, w_rinsq[i]}));
        end
        // Walk from the highest index down so the lowest-index hit is kept
        for (int i = NBALL - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_color = BALL_COLOR[3*i +: 3];
            end
        end
        if (io_bus.swh == 2'b01) begin
            w_color = ~w_color;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rgb   <= 3'b000;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_fs    <= 1'b0;
        end else begin
            r_rgb   <= r_vis1 ? w_color : 3'b000;
            r_hsync <= r_hs1;
            r_vsync <= r_vs1;
            r_fs    <= r_fs1;
        end
    end

    assign io_bus.R           = r_rgb[2];
    assign io_bus.G           = r_rgb[1];
    assign io_bus.B           = r_rgb[0];
    assign io_bus.hsync       = r_hsync;
    assign io_bus.vsync       = r_vsync;
    assign io_bus.frame_start = r_fs;
    assign io_bus.sel         = r_sel;

endmodule

// File: tb/tb_ball_vga_engine.sv
// Directed bench for ball_vga_engine on a reduced raster (56 x 36, 40 x 30 visible).
// Pixel positions are tracked from frame_start: the sample where frame_start is
// high shows pixel (0,0), and each later clock shows the next raster position.
module tb_ball_vga_engine;

    localparam int HA = 40, HF = 4, HS = 6, HB = 6;
    localparam int VA = 30, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   pos = 0;

    ball_vga_if bus ();

    ball_vga_engine #(
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .NBALL    (2),  .STEP    (1),
        .R_MIN    (2),  .R_MAX   (12), .R_INIT (5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] rgb();
        return {bus.R, bus.G, bus.B};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        pos = (pos + 1) % FT;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic goto_px(input int col, input int row);
        advance((row * HT + col - pos + FT) % FT);
    endtask

    task automatic next_frame();
        advance(FT - pos);
    endtask

    task automatic key(input logic [7:0] code);
        bus.kdata  = code;
        bus.kvalid = 1'b1;
        step();
        bus.kvalid = 1'b0;
    endtask

    // Counts clocks until frame_start after a reset release; 0 if never seen
    task automatic wait_release(output int k);
        int n;
        n = 0;
        k = 0;
        while (k == 0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.frame_start === 1'b1) k = n;
        end
        pos = 0;
    endtask

    task automatic test_reset();
        int k;
        bus.kvalid = 1'b0;
        bus.kdata  = 8'h00;
        bus.swh    = 2'b00;
        #23;
        n_vec++;
        if ({bus.hsync, bus.vsync, rgb(), bus.frame_start, bus.sel} !== 8'b1100_0000) begin
            n_err++;
            $display("FAIL reset_state: hs,vs,rgb,fs,sel=%b required 11000000",
                     {bus.hsync, bus.vsync, rgb(), bus.frame_start, bus.sel});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_release(k);
        n_vec++;
        if (k !== 2) begin
            n_err++;
            $display("FAIL reset_fs_latency: clocks=%0d required 2", k);
        end
    endtask

    task automatic test_timing();
        int hs_low = 0, vs_low = 0, fs_cnt = 0, blank_bad = 0;
        int hs_first = -1, hs_last = -1, vs_first = -1;
        for (int i = 0; i < 2 * FT; i++) begin
            if (bus.hsync === 1'b0) begin
                hs_low++;
                if (i < HT && hs_first < 0) hs_first = i;
                if (i < HT) hs_last = i;
            end
            if (bus.vsync === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = i;
            end
            if (bus.frame_start === 1'b1) fs_cnt++;
            if (((pos % HT) >= HA || (pos / HT) >= VA) && rgb() !== 3'b000) blank_bad++;
            step();
        end
        n_vec++;
        if (hs_low !== 2 * VT * HS) begin
            n_err++; $display("FAIL hsync_low_total: %0d required %0d", hs_low, 2 * VT * HS);
        end
        n_vec++;
        if (hs_first !== HA + HF || hs_last !== HA + HF + HS - 1) begin
            n_err++;
            $display("FAIL hsync_window: %0d..%0d required %0d..%0d", hs_first, hs_last,
                     HA + HF, HA + HF + HS - 1);
        end
        n_vec++;
        if (vs_low !== 2 * VS * HT || vs_first !== (VA + VF) * HT) begin
            n_err++;
            $display("FAIL vsync_low: total=%0d first=%0d required %0d first=%0d", vs_low,
                     vs_first, 2 * VS * HT, (VA + VF) * HT);
        end
        n_vec++;
        if (fs_cnt !== 2 || bus.frame_start !== 1'b1) begin
            n_err++;
            $display("FAIL frame_start_period: count=%0d now=%b required 2 and 1", fs_cnt,
                     bus.frame_start);
        end
        n_vec++;
        if (blank_bad !== 0) begin
            n_err++; $display("FAIL blank_rgb: %0d nonzero blank samples required 0", blank_bad);
        end
    endtask

    task automatic test_draw();
        goto_px(0, 0);   n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL draw_bg00: %b required 111", rgb()); end
        goto_px(45, 0);  n_vec++;
        if (rgb() !== 3'b000) begin n_err++; $display("FAIL draw_hblank: %b required 000", rgb()); end
        goto_px(13, 10); n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL draw_top_out: %b required 111", rgb()); end
        goto_px(13, 11); n_vec++;
        if (rgb() !== 3'b110) begin n_err++; $display("FAIL draw_top_in: %b required 110", rgb()); end
        goto_px(8, 15);  n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL draw_left_out: %b required 111", rgb()); end
        goto_px(9, 15);  n_vec++;
        if (rgb() !== 3'b110) begin n_err++; $display("FAIL draw_left_in: %b required 110", rgb()); end
        goto_px(13, 15); n_vec++;
        if (rgb() !== 3'b110) begin n_err++; $display("FAIL draw_ball0: %b required 110", rgb()); end
        goto_px(20, 15); n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL draw_between: %b required 111", rgb()); end
        goto_px(26, 15); n_vec++;
        if (rgb() !== 3'b011) begin n_err++; $display("FAIL draw_ball1: %b required 011", rgb()); end
        goto_px(13, 31); n_vec++;
        if (rgb() !== 3'b000) begin n_err++; $display("FAIL draw_vblank: %b required 000", rgb()); end
    endtask

    task automatic test_move();
        goto_px(0, 1);
        key(8'h23);
        key(8'h23);
        key(8'h23);
        goto_px(18, 15); n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL move_no_tear: %b required 111", rgb()); end
        next_frame();
        goto_px(9, 15);  n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL move_left_edge: %b required 111", rgb()); end
        goto_px(18, 15); n_vec++;
        if (rgb() !== 3'b110) begin n_err++; $display("FAIL move_one_step: %b required 110", rgb()); end
        goto_px(19, 15); n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL move_last_wins: %b required 111", rgb()); end
        next_frame();
        goto_px(18, 15); n_vec++;
        if (rgb() !== 3'b110) begin n_err++; $display("FAIL move_hold_in: %b required 110", rgb()); end
        goto_px(19, 15); n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL move_hold_out: %b required 111", rgb()); end
    endtask

    task automatic test_select();
        key(8'h0D); n_vec++;
        if (bus.sel !== 2'd1) begin n_err++; $display("FAIL select_first: sel=%0d required 1", bus.sel); end
        key(8'h0D); n_vec++;
        if (bus.sel !== 2'd0) begin n_err++; $display("FAIL select_wrap: sel=%0d required 0", bus.sel); end
    endtask

    task automatic test_clamp();
        for (int f = 0; f < 11; f++) begin
            goto_px(0, 2);
            key(8'h1C);
        end
        next_frame();
        goto_px(0, 15);  n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL clamp_col0: %b required 111", rgb()); end
        goto_px(1, 15);  n_vec++;
        if (rgb() !== 3'b110) begin n_err++; $display("FAIL clamp_col1: %b required 110", rgb()); end
        goto_px(9, 15);  n_vec++;
        if (rgb() !== 3'b110) begin n_err++; $display("FAIL clamp_col9: %b required 110", rgb()); end
        goto_px(10, 15); n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL clamp_col10: %b required 111", rgb()); end
        key(8'h79);
        next_frame();
        goto_px(0, 15);  n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL grow_refused_l: %b required 111", rgb()); end
        goto_px(10, 15); n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL grow_refused_r: %b required 111", rgb()); end
        key(8'h0D); n_vec++;
        if (bus.sel !== 2'd1) begin n_err++; $display("FAIL select_ball1: sel=%0d required 1", bus.sel); end
        key(8'h79);
        next_frame();
        goto_px(20, 15); n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL grow_left_out: %b required 111", rgb()); end
        goto_px(31, 15); n_vec++;
        if (rgb() !== 3'b011) begin n_err++; $display("FAIL grow_applied: %b required 011", rgb()); end
        goto_px(32, 15); n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL grow_one_px: %b required 111", rgb()); end
    endtask

    task automatic test_mode();
        bus.swh = 2'b01;
        next_frame();    n_vec++;
        if (rgb() !== 3'b000) begin n_err++; $display("FAIL inv_bg: %b required 000", rgb()); end
        goto_px(45, 0);  n_vec++;
        if (rgb() !== 3'b000) begin n_err++; $display("FAIL inv_blank: %b required 000", rgb()); end
        goto_px(5, 15);  n_vec++;
        if (rgb() !== 3'b001) begin n_err++; $display("FAIL inv_ball0: %b required 001", rgb()); end
        goto_px(26, 15); n_vec++;
        if (rgb() !== 3'b100) begin n_err++; $display("FAIL inv_ball1: %b required 100", rgb()); end
        bus.swh = 2'b11;
        next_frame();    n_vec++;
        if (rgb() !== 3'b000) begin n_err++; $display("FAIL dark_bg: %b required 000", rgb()); end
        goto_px(5, 15);  n_vec++;
        if (rgb() !== 3'b110) begin n_err++; $display("FAIL dark_ball0: %b required 110", rgb()); end
        goto_px(26, 15); n_vec++;
        if (rgb() !== 3'b011) begin n_err++; $display("FAIL dark_ball1: %b required 011", rgb()); end
        bus.swh = 2'b10;
        next_frame();
        goto_px(1, 15);  n_vec++;
        if (rgb() !== 3'b110) begin n_err++; $display("FAIL outline_rim0: %b required 110", rgb()); end
        goto_px(5, 15);  n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL outline_hole0: %b required 111", rgb()); end
        goto_px(21, 15); n_vec++;
        if (rgb() !== 3'b011) begin n_err++; $display("FAIL outline_rim1: %b required 011", rgb()); end
        goto_px(26, 15); n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL outline_hole1: %b required 111", rgb()); end
        bus.swh = 2'b00;
    endtask

    task automatic test_reset_midframe();
        int k;
        next_frame();
        goto_px(26, 15); n_vec++;
        if (rgb() !== 3'b011) begin n_err++; $display("FAIL pre_reset_pix: %b required 011", rgb()); end
        key(8'h23);
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({bus.hsync, bus.vsync, rgb(), bus.frame_start, bus.sel} !== 8'b1100_0000) begin
            n_err++;
            $display("FAIL midframe_reset: hs,vs,rgb,fs,sel=%b required 11000000",
                     {bus.hsync, bus.vsync, rgb(), bus.frame_start, bus.sel});
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        wait_release(k);
        n_vec++;
        if (k !== 2) begin n_err++; $display("FAIL midframe_fs_latency: clocks=%0d required 2", k); end
        next_frame();
        goto_px(13, 15); n_vec++;
        if (rgb() !== 3'b110) begin n_err++; $display("FAIL rst_ball0_home: %b required 110", rgb()); end
        goto_px(18, 15); n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL rst_pending_clr: %b required 111", rgb()); end
        goto_px(26, 15); n_vec++;
        if (rgb() !== 3'b011) begin n_err++; $display("FAIL rst_ball1_home: %b required 011", rgb()); end
        goto_px(31, 15); n_vec++;
        if (rgb() !== 3'b111) begin n_err++; $display("FAIL rst_radius: %b required 111", rgb()); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_draw();
        test_move();
        test_select();
        test_clamp();
        test_mode();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
